spi_pwm_regbank: RTL and testbench
==================================

Name: spi_pwm_regbank

Overview:
- SPI command decoder and register bank for NUM_CH PWM channels; successor of the single-channel decoder in main.
- Sits between spi_slave (byte-level rx/tx) and N pwm instances; holds per-channel freq and duty_cycle_usec registers.
- Provides channel-addressed read/write with 16-bit (DATA_W) little-endian words, read-back on tx_byte, and streaming across channels.

Parameters:
NUM_CH, 4, number of PWM channels (1..16)
DATA_W, 16, register width in bits; multiple of 8, 8..32
DEFAULT_FREQ, 490, reset value of every freq register
DEFAULT_DUTY, 1250, reset value of every duty register

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
ss  in  1  SPI slave select, active-low; high = frame abort/idle
rx_byte_available  in  1  from spi_slave; rising edge = new rx_byte valid
rx_byte  in  8  received byte
tx_byte  out  8  next byte to shift out, registered
pwm_freq  out  NUM_CH*DATA_W  flattened freq registers; ch k at [k*DATA_W +: DATA_W]
pwm_duty_cycle_usec  out  NUM_CH*DATA_W  flattened duty registers, same packing
wr_strobe  out  1  one-cycle pulse when a register is committed
wr_ch  out  4  channel committed with wr_strobe
err  out  1  sticky: access to channel >= NUM_CH seen

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: all freq regs = DEFAULT_FREQ, duty regs = DEFAULT_DUTY, tx_byte = 8'h00, wr_strobe = 0, wr_ch = 0, err = 0, state = S_CMD, byte_cnt = 0, avail_q = 0.
- Priority: rst > ss high > byte event.
- Byte event: rx_byte_available = 1 while avail_q = 0 at a clk edge. avail_q <= rx_byte_available every cycle, including while ss is high.
- Effects of a byte event are visible 1 cycle after the edge that samples it.
- Command byte:
  - [3:0] ch
  - [4] sel (0 = freq, 1 = duty)
  - [5] write
  - [7:6] ignored
- S_CMD, on byte event:
  - latch ch, sel, write; byte_cnt <= 0; go to S_DATA.
  - tx_byte <= byte 0 (LSB) of selected register, or 8'hFF if ch >= NUM_CH.
- S_DATA, on byte event, byte_cnt < DATA_W/8-1:
  - shift byte into assembly buffer at byte position byte_cnt; byte_cnt++.
  - tx_byte <= byte byte_cnt+1 of selected register (8'hFF if invalid).
- S_DATA, final byte (byte_cnt = DATA_W/8-1):
  - If write and ch < NUM_CH: selected register <= assembled word; wr_strobe = 1 for exactly that cycle; wr_ch = ch.
  - If ch >= NUM_CH: no write; err <= 1.
  - byte_cnt <= 0; remain in S_DATA (next word continues stream); tx_byte <= byte 0 of next register (see Optional Feature).
- ss high: state <= S_CMD, byte_cnt <= 0, assembly buffer discarded; partial word never committed; registers, err, tx_byte unchanged.
- Read (write = 0): data bytes received are ignored; registers unchanged; no wr_strobe.
- Read-back source is the register value at the time each tx_byte is loaded. A write in the same word does not alter bytes already loaded.
- err clears only on rst.
- wr_strobe is low in every cycle without a commit.

Optional Feature:
- Macro: SPI_PWM_AUTOINC_EN.
- Defined: after each final byte, ch <= ch+1, wrapping NUM_CH-1 -> 0; sel and write unchanged. A burst of N words after one command accesses N consecutive channels.
  - Invalid ch (>= NUM_CH) increments without wrap until 15, then wraps to 0.
- Undefined: ch unchanged after final byte; subsequent words in the frame re-access the same register.

Test Plan:
- Reset, then read command 8'h10 (ch0 duty) + 2 dummy bytes -> tx_byte sequence 8'hE2, 8'h04 (1250 = 0x04E2); duty unchanged; wr_strobe never high.
- Write 8'h32 (ch2 duty, write), 8'h34, 8'h12 -> pwm_duty_cycle_usec[47:32] = 16'h1234 one cycle after third byte event; wr_strobe 1 cycle with wr_ch = 2; other channels keep 1250/490.
- Write 8'h21 (ch1 freq), byte 8'hAA, ss high, then new frame -> ch1 freq remains 490; new command accepted in S_CMD.
- Write 8'h25 (ch5, NUM_CH = 4) + 2 bytes -> no register change, no wr_strobe, tx_byte = 8'hFF, err = 1 and stays 1 until rst.
- With SPI_PWM_AUTOINC_EN: 8'h33 then words 0x0001, 0x0002 -> ch3 duty = 1, ch0 duty = 2 (wrap); two wr_strobes, wr_ch = 3 then 0. Without the macro -> ch3 duty = 2, ch0 unchanged.
- rx_byte_available held high across 5 cycles -> exactly one byte event; rst asserted mid-word -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/spi_pwm_regbank.sv
// SPI command decoder and per-channel freq/duty register bank for NUM_CH PWM channels.
// Optional macro SPI_PWM_AUTOINC_EN: advance the channel after every word of a streamed frame.
module spi_pwm_regbank #(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 16,
  parameter int DEFAULT_FREQ = 490,
  parameter int DEFAULT_DUTY = 1250
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ss,
  input  logic                     rx_byte_available,
  input  logic [7:0]               rx_byte,
  output logic [7:0]               tx_byte,
  output logic [NUM_CH*DATA_W-1:0] pwm_freq,
  output logic [NUM_CH*DATA_W-1:0] pwm_duty_cycle_usec,
  output logic                     wr_strobe,
  output logic [3:0]               wr_ch,
  output logic                     err
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int ASM_W = (NB > 1) ? (NB - 1) * 8 : 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);

  typedef enum logic {S_CMD, S_DATA} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          byte_cnt_q, byte_cnt_d;
  logic [ASM_W-1:0]          asm_q, asm_d;
  logic [3:0]                ch_q, ch_d;
  logic                      sel_q, sel_d;
  logic                      write_q, write_d;
  logic                      avail_q, avail_d;
  logic [7:0]                tx_q, tx_d;
  logic                      wr_strobe_q, wr_strobe_d;
  logic [3:0]                wr_ch_q, wr_ch_d;
  logic                      err_q, err_d;
  logic [NUM_CH*DATA_W-1:0]  freq_q, freq_d;
  logic [NUM_CH*DATA_W-1:0]  duty_q, duty_d;
  logic                      byte_ev;
  logic [DATA_W-1:0]         word;
  logic [3:0]                ch_nxt;

  function automatic logic ch_valid(input logic [3:0] c);
    return {1'b0, c} < 5'(NUM_CH);
  endfunction

  function automatic logic [DATA_W-1:0] rd_word(input logic [3:0] c, input logic s,
                                                input logic [NUM_CH*DATA_W-1:0] fq,
                                                input logic [NUM_CH*DATA_W-1:0] dq);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (c == 4'(k)) w = s ? dq[k*DATA_W +: DATA_W] : fq[k*DATA_W +: DATA_W];
    end
    return w;
  endfunction

  // Invalid channels read back as all-ones so the master can detect them.
  function automatic logic [7:0] rd_byte(input logic [3:0] c, input logic s,
                                         input logic [CNT_W-1:0] idx,
                                         input logic [NUM_CH*DATA_W-1:0] fq,
                                         input logic [NUM_CH*DATA_W-1:0] dq);
    logic [DATA_W-1:0] w;
    if (!ch_valid(c)) return 8'hFF;
    w = rd_word(c, s, fq, dq);
    return w[8*idx +: 8];
  endfunction

  function automatic logic [3:0] ch_step(input logic [3:0] c);
`ifdef SPI_PWM_AUTOINC_EN
    if (ch_valid(c) && c == 4'(NUM_CH - 1)) return 4'd0;
    return c + 4'd1;
`else
    return c;
`endif
  endfunction

  assign byte_ev = rx_byte_available & ~avail_q;
  assign word    = (NB == 1) ? DATA_W'(rx_byte) : DATA_W'({rx_byte, asm_q});
  assign ch_nxt  = ch_step(ch_q);

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    ch_d        = ch_q;
    sel_d       = sel_q;
    write_d     = write_q;
    avail_d     = rx_byte_available;
    tx_d        = tx_q;
    wr_strobe_d = 1'b0;
    wr_ch_d     = wr_ch_q;
    err_d       = err_q;
    freq_d      = freq_q;
    duty_d      = duty_q;
    if (ss) begin
      state_d    = S_CMD;
      byte_cnt_d = '0;
      asm_d      = '0;
    end else if (byte_ev) begin
      case (state_q)
        S_CMD: begin
          ch_d       = rx_byte[3:0];
          sel_d      = rx_byte[4];
          write_d    = rx_byte[5];
          byte_cnt_d = '0;
          asm_d      = '0;
          state_d    = S_DATA;
          tx_d       = rd_byte(rx_byte[3:0], rx_byte[4], '0, freq_q, duty_q);
        end
        default: begin
          if (byte_cnt_q != LAST) begin
            asm_d[8*byte_cnt_q +: 8] = rx_byte;
            byte_cnt_d = byte_cnt_q + 1'b1;
            tx_d       = rd_byte(ch_q, sel_q, byte_cnt_q + 1'b1, freq_q, duty_q);
          end else begin
            if (!ch_valid(ch_q)) begin
              err_d = 1'b1;
            end else if (write_q) begin
              for (int k = 0; k < NUM_CH; k++) begin
                if (ch_q == 4'(k)) begin
                  if (sel_q) duty_d[k*DATA_W +: DATA_W] = word;
                  else       freq_d[k*DATA_W +: DATA_W] = word;
                end
              end
              wr_strobe_d = 1'b1;
              wr_ch_d     = ch_q;
            end
            byte_cnt_d = '0;
            asm_d      = '0;
            ch_d       = ch_nxt;
            // Preload of the next word reads pre-commit register values.
            tx_d       = rd_byte(ch_nxt, sel_q, '0, freq_q, duty_q);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CMD;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      ch_q        <= '0;
      sel_q       <= 1'b0;
      write_q     <= 1'b0;
      avail_q     <= 1'b0;
      tx_q        <= 8'h00;
      wr_strobe_q <= 1'b0;
      wr_ch_q     <= '0;
      err_q       <= 1'b0;
      freq_q      <= {NUM_CH{DATA_W'(DEFAULT_FREQ)}};
      duty_q      <= {NUM_CH{DATA_W'(DEFAULT_DUTY)}};
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      ch_q        <= ch_d;
      sel_q       <= sel_d;
      write_q     <= write_d;
      avail_q     <= avail_d;
      tx_q        <= tx_d;
      wr_strobe_q <= wr_strobe_d;
      wr_ch_q     <= wr_ch_d;
      err_q       <= err_d;
      freq_q      <= freq_d;
      duty_q      <= duty_d;
    end
  end

  assign tx_byte             = tx_q;
  assign pwm_freq            = freq_q;
  assign pwm_duty_cycle_usec = duty_q;
  assign wr_strobe           = wr_strobe_q;
  assign wr_ch               = wr_ch_q;
  assign err                 = err_q;

endmodule

// File: tb/tb_spi_pwm_regbank.sv
// Scoreboard bench for spi_pwm_regbank: expected tx bytes and commits are queued as bytes are sent.
module tb_spi_pwm_regbank;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam logic [15:0] DF = 16'd490;
  localparam logic [15:0] DD = 16'd1250;

  logic                     clk;
  logic                     rst;
  logic                     ss;
  logic                     rx_avail;
  logic [7:0]               rx_byte;
  logic [7:0]               tx_byte;
  logic [NUM_CH*DATA_W-1:0] pwm_freq;
  logic [NUM_CH*DATA_W-1:0] pwm_duty;
  logic                     wr_strobe;
  logic [3:0]               wr_ch;
  logic                     err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  tx_exp_q[$];
  logic [3:0]  wr_exp_q[$];
  logic [15:0] m_freq[NUM_CH];
  logic [15:0] m_duty[NUM_CH];

  spi_pwm_regbank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEFAULT_FREQ(490), .DEFAULT_DUTY(1250)) dut (
    .clk(clk), .rst(rst), .ss(ss), .rx_byte_available(rx_avail), .rx_byte(rx_byte),
    .tx_byte(tx_byte), .pwm_freq(pwm_freq), .pwm_duty_cycle_usec(pwm_duty),
    .wr_strobe(wr_strobe), .wr_ch(wr_ch), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] flat(input logic [15:0] a0, input logic [15:0] a1,
                                       input logic [15:0] a2, input logic [15:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic check_regs(input string tag);
    check({tag, "_freq"}, pwm_freq, flat(m_freq[0], m_freq[1], m_freq[2], m_freq[3]));
    check({tag, "_duty"}, pwm_duty, flat(m_duty[0], m_duty[1], m_duty[2], m_duty[3]));
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_freq[k] = DF;
      m_duty[k] = DD;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] exp_tx, input bit chk);
    logic [7:0] e;
    if (chk) tx_exp_q.push_back(exp_tx);
    @(negedge clk);
    rx_byte  = b;
    rx_avail = 1'b1;
    @(negedge clk);
    rx_avail = 1'b0;
    if (chk) begin
      e = tx_exp_q.pop_front();
      check("tx_byte", tx_byte, e);
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    ss = 1'b1;
    @(negedge clk);
    ss = 1'b0;
  endtask

  // Every commit pulse must match the next queued channel.
  always @(negedge clk) begin
    if (wr_strobe) begin
      if (wr_exp_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
      else check("wr_ch", wr_ch, wr_exp_q.pop_front());
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ss = 1'b1; rx_avail = 1'b0; rx_byte = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_tx", tx_byte, 8'h00);
    check("rst_wr", wr_strobe, 1'b0);
    check("rst_err", err, 1'b0);
    check_regs("rst");
    rst = 1'b0;
    @(negedge clk);
    ss = 1'b0;

    // read ch0 duty
    send_byte(8'h10, 8'hE2, 1);
    send_byte(8'h00, 8'h04, 1);
    send_byte(8'h00, 8'hE2, 1);
    check_regs("read0");
    end_frame();

    // write ch2 duty = 0x1234
    send_byte(8'h32, 8'hE2, 1);
    send_byte(8'h34, 8'h04, 1);
    wr_exp_q.push_back(4'd2);
    m_duty[2] = 16'h1234;
    send_byte(8'h12, 8'h00, 0);
    check_regs("write2");
    check("write2_err", err, 1'b0);
    end_frame();

    // aborted partial write to ch1 freq, then fresh read of ch1 freq
    send_byte(8'h21, 8'hEA, 1);
    send_byte(8'hAA, 8'h01, 1);
    end_frame();
    check_regs("abort");
    send_byte(8'h01, 8'hEA, 1);
    send_byte(8'h00, 8'h01, 1);
    end_frame();

    // invalid channel write
    send_byte(8'h25, 8'hFF, 1);
    send_byte(8'h77, 8'hFF, 1);
    send_byte(8'h66, 8'hFF, 1);
    check("inv_err", err, 1'b1);
    check_regs("inv");
    end_frame();

    // streamed words after one write command to ch3 duty
    send_byte(8'h33, 8'hE2, 1);
    send_byte(8'h01, 8'h04, 1);
    wr_exp_q.push_back(4'd3);
    m_duty[3] = 16'h0001;
    send_byte(8'h00, 8'h00, 0);
`ifdef SPI_PWM_AUTOINC_EN
    send_byte(8'h02, 8'h04, 1);
    wr_exp_q.push_back(4'd0);
    m_duty[0] = 16'h0002;
`else
    send_byte(8'h02, 8'h00, 1);
    wr_exp_q.push_back(4'd3);
    m_duty[3] = 16'h0002;
`endif
    send_byte(8'h00, 8'h00, 0);
    check_regs("stream");
    check("stream_err", err, 1'b1);
    end_frame();

    // level-held available produces a single byte event
    @(negedge clk);
    rx_byte  = 8'h01;
    rx_avail = 1'b1;
    repeat (5) @(negedge clk);
    rx_avail = 1'b0;
    check("hold_tx", tx_byte, 8'hEA);
    send_byte(8'h00, 8'h01, 1);
    check_regs("hold");
    end_frame();

    // reset in the middle of a write word
    send_byte(8'h32, m_duty[2][7:0], 1);
    send_byte(8'h55, m_duty[2][15:8], 1);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    check("mid_rst_tx", tx_byte, 8'h00);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_wr", wr_strobe, 1'b0);
    check("mid_rst_wrch", wr_ch, 4'd0);
    check_regs("mid_rst");
    rst = 1'b0;
    send_byte(8'h10, 8'hE2, 1);
    send_byte(8'h00, 8'h04, 1);
    end_frame();

    repeat (2) @(negedge clk);
    check("wr_pending", wr_exp_q.size(), 0);
    check("tx_pending", tx_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
